// File: rtl/toggle_cmd_sequencer_if.sv
// Bundle of control, feedback and status signals between a test/control
// master and the toggle command sequencer.
interface toggle_cmd_sequencer_if #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int PERW   = 8
);
    logic              start;
    logic              abort;
    logic [MAXLEN-1:0] pattern;
    logic [LENW-1:0]   len;
    logic [PERW-1:0]   period;
    logic              fb;
    logic [1:0]        cmd;
    logic              busy;
    logic              done;
    logic              exp;
    logic              err;

    // Controller side: requests runs and supplies the target's feedback.
    modport master (
        output start, abort, pattern, len, period, fb,
        input  cmd, busy, done, exp, err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, pattern, len, period, fb,
        output cmd, busy, done, exp, err
    );
endinterface

// File: rtl/toggle_cmd_sequencer.sv
// Command sequencer for the two-bit toggle Moore machine: arms the target,
// plays a bit pattern into it one step per period, models the target's
// output and flags any disagreement with the real feedback.
// MAXLEN must be at least 2 (the next pattern bit is read from bit 1).
module toggle_cmd_sequencer #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int PERW   = 8
) (
    input logic                   clk,
    input logic                   reset,
    toggle_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t            state;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic [LENW-1:0]   step_q;
    logic [PERW-1:0]   per_q;
    logic [PERW-1:0]   gap_q;
    logic [1:0]        cmd_q;
    logic              busy_q;
    logic              done_q;
    logic              exp_q;
    logic              err_q;

    logic [LENW-1:0]   len_clamped;
    logic [PERW-1:0]   per_clamped;
    logic              step_first;
    logic              step_last;

    // Clamp the requested length and period before they are latched.
    always_comb begin
        len_clamped = (bus.len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : bus.len;
        per_clamped = (bus.period < PERW'(2)) ? PERW'(2) : bus.period;
    end

    // The gap counter runs P-1 down to 0 within a step; P>=2 keeps the
    // first and last cycle of a step distinct.
    assign step_first = (gap_q == (per_q - PERW'(1)));
    assign step_last  = (gap_q == '0);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pat_q  <= '0;
            len_q  <= '0;
            per_q  <= '0;
            step_q <= '0;
            gap_q  <= '0;
            cmd_q  <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            exp_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_q  <= 2'b00;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pat_q  <= bus.pattern;
                        len_q  <= len_clamped;
                        per_q  <= per_clamped;
                        err_q  <= 1'b0;
                        cmd_q  <= 2'b10;
                        busy_q <= 1'b1;
                        state  <= ARM;
                    end
                end

                ARM: begin
                    if (bus.abort) begin
                        cmd_q  <= 2'b00;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        exp_q <= 1'b0;
                        if (len_q == '0) begin
                            cmd_q  <= 2'b00;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cmd_q  <= pat_q[0] ? 2'b01 : 2'b00;
                            step_q <= '0;
                            gap_q  <= per_q - PERW'(1);
                            state  <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        cmd_q  <= 2'b00;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (step_first) begin
                            exp_q <= exp_q ^ pat_q[0];
                        end
                        if (step_last) begin
                            if (bus.fb != exp_q) begin
                                err_q <= 1'b1;
                            end
                            if (step_q == (len_q - LENW'(1))) begin
                                cmd_q  <= 2'b00;
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                step_q <= step_q + LENW'(1);
                                pat_q  <= pat_q >> 1;
                                cmd_q  <= pat_q[1] ? 2'b01 : 2'b00;
                                gap_q  <= per_q - PERW'(1);
                            end
                        end else begin
                            cmd_q <= 2'b00;
                            gap_q <= gap_q - PERW'(1);
                        end
                    end
                end

                DONE: begin
                    cmd_q  <= 2'b00;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    cmd_q  <= 2'b00;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd  = cmd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.exp  = exp_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_toggle_cmd_sequencer.sv
// Testbench for toggle_cmd_sequencer: a reference model expands each run
// into a per-cycle expected trace that a monitor compares against the DUT.
module tb_toggle_cmd_sequencer;

    typedef struct packed {
        logic [1:0] cmd;
        logic       busy;
        logic       done;
        logic       ex;
        logic       er;
    } expect_t;

    logic    clk;
    logic    reset;
    logic    tgt;
    int      fb_mode;
    int      total;
    int      bad;
    int      cyc;
    logic    mdl_exp;
    logic    mdl_err;
    expect_t expq[$];

    toggle_cmd_sequencer_if #(.MAXLEN(16), .LENW(5), .PERW(8)) sif ();

    toggle_cmd_sequencer #(.MAXLEN(16), .LENW(5), .PERW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural toggle target: 10 arms to 0, 01 toggles, 00 holds.
    always @(posedge clk) begin
        if (reset) tgt <= 1'b0;
        else if (sif.cmd == 2'b10) tgt <= 1'b0;
        else if (sif.cmd == 2'b01) tgt <= ~tgt;
    end

    // Feedback either comes from the healthy target or is stuck at a level.
    assign sif.fb = (fb_mode == 0) ? tgt : ((fb_mode == 1) ? 1'b0 : 1'b1);

    task automatic check_output(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle out of reset, compare against the next expected
    // entry, or against the idle state once the trace is exhausted.
    initial begin
        expect_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    mdl_exp = e.ex;
                    mdl_err = e.er;
                end else begin
                    e.cmd  = 2'b00;
                    e.busy = 1'b0;
                    e.done = 1'b0;
                    e.ex   = mdl_exp;
                    e.er   = mdl_err;
                end
                check_output("cmd",  int'(sif.cmd),  int'(e.cmd));
                check_output("busy", int'(sif.busy), int'(e.busy));
                check_output("done", int'(sif.done), int'(e.done));
                check_output("exp",  int'(sif.exp),  int'(e.ex));
                check_output("err",  int'(sif.err),  int'(e.er));
            end
        end
    end

    task automatic do_reset();
        sif.start = 1'b0;
        sif.abort = 1'b0;
        reset = 1'b1;
        expq.delete();
        mdl_exp = 1'b0;
        mdl_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Issue one run; abort_at / extra_start_at / reset_at name the cycle
    // (1 = ARM cycle) in which that event is driven, 0 for never.
    task automatic apply_stimulus(input logic [15:0] pat, input int ln, input int per,
                                  input int fbm, input int abort_at, input int extra_start_at,
                                  input bit abort_with_start, input int reset_at);
        expect_t tr[$];
        expect_t e;
        int      lc;
        int      pc;
        logic    ex;
        logic    er;
        logic    fbv;
        lc = (ln > 16) ? 16 : ln;
        pc = (per < 2) ? 2 : per;

        // Arm cycle shows the value held from before the run.
        e.cmd = 2'b10; e.busy = 1'b1; e.done = 1'b0; e.ex = mdl_exp; e.er = 1'b0;
        tr.push_back(e);
        ex = 1'b0;
        er = 1'b0;
        for (int i = 0; i < lc; i++) begin
            for (int k = 0; k < pc; k++) begin
                e.cmd  = (k == 0 && pat[i]) ? 2'b01 : 2'b00;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.ex   = ex;
                e.er   = er;
                tr.push_back(e);
                if (k == 0) ex = ex ^ pat[i];
                if (k == pc - 1) begin
                    fbv = (fbm == 0) ? ex : ((fbm == 1) ? 1'b0 : 1'b1);
                    if (fbv != ex) er = 1'b1;
                end
            end
        end
        e.cmd = 2'b00; e.busy = 1'b1; e.done = 1'b1; e.ex = ex; e.er = er;
        tr.push_back(e);
        if (abort_at >= 1 && abort_at <= 1 + lc * pc) begin
            while (tr.size() > abort_at) tr.delete(tr.size() - 1);
        end

        fb_mode     = fbm;
        sif.pattern = pat;
        sif.len     = 5'(ln);
        sif.period  = 8'(per);
        sif.start   = 1'b1;
        sif.abort   = abort_with_start;
        @(posedge clk);
        #1;
        foreach (tr[j]) expq.push_back(tr[j]);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        for (int c = 1; c <= tr.size(); c++) begin
            if (c == reset_at) begin
                do_reset();
                break;
            end
            sif.abort   = (c == abort_at);
            sif.start   = (c == extra_start_at);
            sif.pattern = 16'($urandom);
            sif.len     = 5'($urandom);
            sif.period  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        sif.start = 1'b0;
        sif.abort = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed scenarios followed by randomized runs.
    initial begin
        int ln;
        int per;
        int lc;
        int pc;
        int ab;
        int xs;
        total       = 0;
        bad         = 0;
        fb_mode     = 0;
        mdl_exp     = 1'b0;
        mdl_err     = 1'b0;
        reset       = 1'b1;
        sif.start   = 1'b0;
        sif.abort   = 1'b0;
        sif.pattern = '0;
        sif.len     = '0;
        sif.period  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] basic run");
        apply_stimulus(16'h000B, 4, 2, 0, 0, 0, 1'b0, 0);
        $display("[TB] mismatch with fb stuck low");
        apply_stimulus(16'h0001, 1, 3, 1, 0, 0, 1'b0, 0);
        $display("[TB] len clamp and period clamp");
        apply_stimulus(16'hA5C3, 31, 2, 0, 0, 0, 1'b0, 0);
        apply_stimulus(16'h3C96, 16, 0, 0, 0, 0, 1'b0, 0);
        apply_stimulus(16'h00FF, 4, 1, 2, 0, 0, 1'b0, 0);
        $display("[TB] zero length");
        apply_stimulus(16'hFFFF, 0, 3, 0, 0, 0, 1'b0, 0);
        $display("[TB] abort in step 2, start while busy, start with abort");
        apply_stimulus(16'h0007, 4, 2, 0, 6, 0, 1'b0, 0);
        apply_stimulus(16'h0005, 3, 3, 0, 0, 4, 1'b0, 0);
        apply_stimulus(16'h0009, 4, 2, 1, 1, 0, 1'b1, 0);
        apply_stimulus(16'h0003, 2, 2, 1, 10, 0, 1'b0, 0);
        $display("[TB] reset mid-run then clean run");
        apply_stimulus(16'hFFFF, 8, 2, 1, 0, 0, 1'b0, 8);
        apply_stimulus(16'h000B, 4, 2, 0, 0, 0, 1'b0, 0);

        $display("[TB] random runs");
        for (int r = 0; r < 40; r++) begin
            ln  = $urandom_range(0, 31);
            per = $urandom_range(0, 5);
            lc  = (ln > 16) ? 16 : ln;
            pc  = (per < 2) ? 2 : per;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + lc * pc) : 0;
            xs  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + lc * pc) : 0;
            apply_stimulus(16'($urandom), ln, per, $urandom_range(0, 2), ab, xs,
                           1'($urandom_range(0, 1)), 0);
        end

        check_output("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_cmd_sequencer.md
# toggle_cmd_sequencer

Command sequencer for the two-bit-controlled toggle Moore machine. It arms the target with command 2'b10, then plays a programmed bit pattern into it, one step per programmed period. A 1 step issues a toggle (2'b01) and a 0 step issues a hold (2'b00). The sequencer models the target's expected output and flags any mismatch against the target's actual output. It sits between software/test control and the toggle machine and is that machine's only driver of `a`.

## Interface
- MAXLEN, 16, maximum pattern length in steps
- LENW, 5, width of `len`; must satisfy 2^LENW > MAXLEN
- PERW, 8, width of `period`
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  terminate a run in progress
- pattern  in  MAXLEN  step bits; bit 0 is played first
- len  in  LENW  number of steps to play
- period  in  PERW  cycles per step
- fb  in  1  target's `out`
- cmd  out  2  drives target's `a`
- busy  out  1  high in ARM, RUN and DONE
- done  out  1  one-cycle pulse at normal completion
- exp  out  1  modelled target output
- err  out  1  sticky mismatch flag

## Operation
- States: IDLE, ARM, RUN, DONE.
- Reset values: state IDLE, cmd=00, busy=0, done=0, exp=0, err=0, step and gap counters 0.
- IDLE
  - cmd=00.
  - On start=1: latch pattern, len and period; clear err; go to ARM.
  - Latched len is clamped to MAXLEN if larger.
  - Latched period is clamped to 2 if 0 or 1.
- ARM: one cycle, cmd=10, exp<=0. Go to RUN if len>0, else DONE.
- RUN, step i (0..len-1), P = latched period:
  - First cycle of the step: cmd = pattern[i] ? 01 : 00. If pattern[i]=1, exp toggles at the end of this cycle.
  - Remaining P-1 cycles: cmd=00.
  - Last cycle of the step: if fb != exp, set err.
  - After the last step's last cycle, go to DONE.
- DONE: one cycle, cmd=00, done=1, then IDLE.
- abort in ARM or RUN:
  - Next cycle is IDLE with cmd=00.
  - No done pulse; err and exp are held.
  - abort has priority over step advance and over the DONE transition.
- abort in IDLE or DONE has no effect.
- start while busy is ignored and is not queued.
- Latched inputs are stable for the whole run; changes to pattern, len and period during a run have no effect.
- err stays set until the next accepted start or reset.
- cmd never takes the value 11.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- start sampled at edge T:
  - ARM at cycle T+1.
  - Step i command at T+2+i·P.
  - Step i compare at T+1+(i+1)·P.
  - DONE (done=1) at T+2+len·P; busy falls the cycle after.
- len=0: ARM at T+1, DONE at T+2.
- Target toggle timing: the target toggles on the edge ending the 01 cycle, so fb is valid from the next cycle on. The P≥2 clamp guarantees the compare sees the updated fb.
- The step counter wraps nowhere: the run terminates at len.
- The gap counter reloads to P-1 on every step command.
- reset mid-run: the next cycle is IDLE with reset values; the target must be re-armed by a new start.
- start and abort together in IDLE: start wins, abort ignored.

## Test plan
- Basic run: pattern=16'h000B, len=4, period=2, fb from a correct target model.
  - Required cmd sequence: 10,01,00,01,00,00,00,01,00.
  - Required exp after each step: 1,0,0,1.
  - done at T+10; err=0.
- Mismatch: fb forced 0 with pattern=1, len=1, period=3 → err=1 at compare cycle T+4; done still pulses at T+5.
- Clamping:
  - len=31 → 16 steps.
  - period=0 → P=2; done at T+2+32.
- len=0 → cmd=10 at T+1, done at T+2, no 01 ever issued.
- Abort and busy-start:
  - abort during step 2 → cmd=00 next cycle, IDLE, no done pulse.
  - start while busy → ignored; run timing unchanged.
- Reset mid-RUN → all outputs at reset values the next cycle. A new start then runs normally with err cleared.
